// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
// Shared types and default configuration for the IR scan sequencer.
//   ir_state_t   : scan FSM states (idle, emitter settle, sample, emitter off)
//   IR_*_DFLT    : default scan period, settle time and filter depth
// ---------------------------------------------------------------------------
package ir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_OFF
    } ir_state_t;

    localparam int unsigned IR_PERIOD_DFLT = 2048;
    localparam int unsigned IR_SETTLE_DFLT = 256;
    localparam int unsigned IR_FILT_N_DFLT = 3;

endpackage

// File: rtl/ir_glitch_filt.sv
// ---------------------------------------------------------------------------
// ir_glitch_filt
// One IR channel: 2-flop synchronizer on the raw active-low input, inversion
// to active-high, optional N-in-a-row acceptance filter, and the accepted
// level register.
// Optional feature macro: IR_GLITCH_FILT_EN (adds the FILT_N history filter).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   raw_n      : raw asynchronous active-low sensor input
//   smpl       : capture strobe (one cycle, from the scan FSM)
//   clr        : clears accepted level and history (scanning disabled)
//   level      : accepted active-high level (registered)
//   level_nxt  : level that will be accepted if smpl is high this cycle
// ---------------------------------------------------------------------------
module ir_glitch_filt
    import ir_pkg::*;
`ifdef IR_GLITCH_FILT_EN
#(
    parameter int unsigned FILT_N = IR_FILT_N_DFLT
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    input  logic smpl,
    input  logic clr,
    output logic level,
    output logic level_nxt
);

    // Synchronizer resets to the inactive (high) pin level.
    logic [1:0] sync_n;
    logic       synced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_n <= '1;
        end else begin
            sync_n <= {sync_n[0], raw_n};
        end
    end

    assign synced = ~sync_n[1];

`ifdef IR_GLITCH_FILT_EN
    if (FILT_N < 2) begin : g_no_hist
        assign level_nxt = synced;
    end else begin : g_hist
        // The window is the stored FILT_N-1 previous samples plus the current
        // one; a level is accepted only when the whole window agrees.
        logic [FILT_N-2:0] hist;
        logic [FILT_N-1:0] window;

        assign window = {hist, synced};

        always_comb begin
            level_nxt = level;
            if (&window) begin
                level_nxt = 1'b1;
            end else if (~|window) begin
                level_nxt = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hist <= '0;
            end else if (clr) begin
                hist <= '0;
            end else if (smpl) begin
                hist <= window[FILT_N-2:0];
            end
        end
    end
`else
    assign level_nxt = synced;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
        end else if (clr) begin
            level <= 1'b0;
        end else if (smpl) begin
            level <= level_nxt;
        end
    end

endmodule

// File: rtl/ir_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ir_scan_ctrl
// Duty-cycles the IR emitter, samples the three IR sensors after a settle
// time, and presents qualified levels, a center-line rise pulse and a
// saturating crossing count.
// Optional feature macro: IR_GLITCH_FILT_EN (FILT_N-sample acceptance filter).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : scanning enabled
//   clr_cnt           : synchronous clear of line_cnt
//   lftIR_n/cntrIR_n/rghtIR_n : raw active-low sensor inputs
//   IR_en             : emitter enable
//   lftIR/cntrIR/rghtIR : qualified active-high levels
//   smpl_vld          : one-cycle pulse when levels update
//   cntr_rise         : one-cycle pulse on accepted 0->1 of cntrIR
//   line_cnt          : center-line crossings, saturates at 15
// ---------------------------------------------------------------------------
module ir_scan_ctrl
    import ir_pkg::*;
#(
    parameter int unsigned PERIOD = IR_PERIOD_DFLT,
    parameter int unsigned SETTLE = IR_SETTLE_DFLT,
    parameter int unsigned FILT_N = IR_FILT_N_DFLT
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr_cnt,
    input  logic       lftIR_n,
    input  logic       cntrIR_n,
    input  logic       rghtIR_n,
    output logic       IR_en,
    output logic       lftIR,
    output logic       cntrIR,
    output logic       rghtIR,
    output logic       smpl_vld,
    output logic       cntr_rise,
    output logic [3:0] line_cnt
);

    localparam int unsigned     CW          = $clog2(PERIOD);
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   OFF_LAST    = CW'(PERIOD - SETTLE - 2);

    ir_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          smpl;
    logic          rise;
    logic [2:0]    raw_n;
    logic [2:0]    lvl;
    logic [2:0]    lvl_nxt;

    // Counter reloads to 0 on every state change and holds in IDLE/SAMPLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   state_nxt = ST_SETTLE;
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state_nxt = ST_SAMPLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                ST_SAMPLE: state_nxt = ST_OFF;
                ST_OFF: begin
                    if (cnt == OFF_LAST) begin
                        state_nxt = ST_SETTLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // A capture only happens if en is still high at the SAMPLE edge.
    assign smpl = en && (state == ST_SAMPLE);
    assign rise = smpl && lvl_nxt[1] && !lvl[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            IR_en     <= 1'b0;
            smpl_vld  <= 1'b0;
            cntr_rise <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            // Registered from next state so the emitter pin is glitch-free.
            IR_en     <= (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE);
            smpl_vld  <= smpl;
            cntr_rise <= rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt <= '0;
        end else if (clr_cnt) begin
            line_cnt <= rise ? 4'd1 : 4'd0;
        end else if (rise && (line_cnt != 4'hF)) begin
            line_cnt <= line_cnt + 4'd1;
        end
    end

    assign raw_n = {lftIR_n, cntrIR_n, rghtIR_n};

    for (genvar i = 0; i < 3; i++) begin : g_ch
`ifdef IR_GLITCH_FILT_EN
        ir_glitch_filt #(.FILT_N(FILT_N)) u_filt (
`else
        ir_glitch_filt u_filt (
`endif
            .clk       (clk),
            .rst_n     (rst_n),
            .raw_n     (raw_n[i]),
            .smpl      (smpl),
            .clr       (!en),
            .level     (lvl[i]),
            .level_nxt (lvl_nxt[i])
        );
    end

`ifndef IR_GLITCH_FILT_EN
    // FILT_N has no effect without the filter; kept in the parameter list so
    // both builds share one interface.
    if (FILT_N == 0) begin : g_filt_n_unused
    end
`endif

    assign {lftIR, cntrIR, rghtIR} = lvl;

endmodule

// File: tb/tb_ir_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ir_scan_ctrl
// Scoreboard bench for ir_scan_ctrl with PERIOD=64, SETTLE=8.
// A reference model tracks scan phase with modular arithmetic and pushes the
// expected sample into a queue; a monitor pops it whenever smpl_vld appears.
// ---------------------------------------------------------------------------
module tb_ir_scan_ctrl;

    localparam int PERIOD = 64;
    localparam int SETTLE = 8;
    localparam int FILT_N = 3;
`ifdef IR_GLITCH_FILT_EN
    localparam int HOLD = FILT_N;
`else
    localparam int HOLD = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       lftIR_n = 1'b1;
    logic       cntrIR_n = 1'b1;
    logic       rghtIR_n = 1'b1;
    logic       IR_en, lftIR, cntrIR, rghtIR, smpl_vld, cntr_rise;
    logic [3:0] line_cnt;

    ir_scan_ctrl #(.PERIOD(PERIOD), .SETTLE(SETTLE), .FILT_N(FILT_N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr_cnt   (clr_cnt),
        .lftIR_n   (lftIR_n),
        .cntrIR_n  (cntrIR_n),
        .rghtIR_n  (rghtIR_n),
        .IR_en     (IR_en),
        .lftIR     (lftIR),
        .cntrIR    (cntrIR),
        .rghtIR    (rghtIR),
        .smpl_vld  (smpl_vld),
        .cntr_rise (cntr_rise),
        .line_cnt  (line_cnt)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    task automatic check(string name, int act, int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0] lvl;
        logic       rise;
    } exp_t;

    exp_t       sb[$];
    bit         m_act;
    int         m_ph;
    bit         m_iren;
    logic [2:0] m_lvl;
    int         m_cnt;
    bit         m_smpl_now;
    int         run_len[3];
    bit         run_val[3];

    // m_ph counts cycles since the emitter first came on in this run; the
    // emitter is on for phases 0..SETTLE and the sample lands at SETTLE+1.
    always @(posedge clk or negedge rst_n) begin
        logic [2:0] s;
        logic [2:0] nl;
        bit         smpl;
        bit         rise;
        if (!rst_n) begin
            m_act = 0; m_ph = 0; m_iren = 0; m_lvl = '0; m_cnt = 0; m_smpl_now = 0;
            sb.delete();
            for (int i = 0; i < 3; i++) begin run_len[i] = FILT_N; run_val[i] = 0; end
        end else begin
            cyc++;
            smpl = 0;
            rise = 0;
            if (!en) begin
                m_act = 0;
                m_lvl = '0;
                for (int i = 0; i < 3; i++) begin run_len[i] = FILT_N; run_val[i] = 0; end
            end else if (!m_act) begin
                m_act = 1;
                m_ph  = 0;
            end else begin
                m_ph = (m_ph + 1) % PERIOD;
                smpl = (m_ph == SETTLE + 1);
            end
            if (smpl) begin
                s = ~{lftIR_n, cntrIR_n, rghtIR_n};
                for (int i = 0; i < 3; i++) begin
`ifdef IR_GLITCH_FILT_EN
                    if (s[i] == run_val[i]) run_len[i]++;
                    else begin run_val[i] = s[i]; run_len[i] = 1; end
                    nl[i] = (run_len[i] >= FILT_N) ? run_val[i] : m_lvl[i];
`else
                    nl[i] = s[i];
`endif
                end
                rise  = nl[1] && !m_lvl[1];
                m_lvl = nl;
                sb.push_back('{lvl: nl, rise: rise});
            end
            if (clr_cnt) m_cnt = rise ? 1 : 0;
            else if (rise && m_cnt < 15) m_cnt++;
            m_iren     = m_act && (m_ph <= SETTLE);
            m_smpl_now = smpl;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                check("IR_en", IR_en, m_iren);
                check("levels", {lftIR, cntrIR, rghtIR}, m_lvl);
                check("line_cnt", line_cnt, m_cnt);
                if (smpl_vld) begin
                    if (sb.size() == 0) begin
                        check("smpl_vld_unexpected", smpl_vld, 0);
                    end else begin
                        e = sb.pop_front();
                        check("smpl_levels", {lftIR, cntrIR, rghtIR}, e.lvl);
                        check("cntr_rise", cntr_rise, e.rise);
                    end
                end else begin
                    check("cntr_rise_without_vld", cntr_rise, 0);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("smpl_vld_missing", smpl_vld, 1);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_sample();
        int n = 0;
        do begin step(1); n++; end while (!m_smpl_now && n < 4 * PERIOD);
        if (!m_smpl_now) check("sample_wait_timeout", m_smpl_now, 1);
    endtask

    task automatic wait_pre_sample();
        int n = 0;
        do begin step(1); n++; end while (!(m_act && m_ph == SETTLE) && n < 4 * PERIOD);
        if (!(m_act && m_ph == SETTLE)) check("presample_wait_timeout", m_ph, SETTLE);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_IR_en", IR_en, 0);
        check("rst_lftIR", lftIR, 0);
        check("rst_cntrIR", cntrIR, 0);
        check("rst_rghtIR", rghtIR, 0);
        check("rst_smpl_vld", smpl_vld, 0);
        check("rst_cntr_rise", cntr_rise, 0);
        check("rst_line_cnt", line_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        step(2);

        // First scans: center line seen for one scan only.
        cntrIR_n = 1'b0;
        en = 1'b1;
        wait_sample();
        check("first_smpl_vld", smpl_vld, 1);
`ifndef IR_GLITCH_FILT_EN
        check("first_cntrIR", cntrIR, 1);
        check("first_cntr_rise", cntr_rise, 1);
        check("first_line_cnt", line_cnt, 1);
`endif
        cntrIR_n = 1'b1;
        wait_sample();
        check("second_smpl_vld", smpl_vld, 1);
        check("second_cntrIR", cntrIR, 0);

        // 17 crossings saturate the counter; clear coincident with a rise.
        for (int i = 0; i < 17; i++) begin
            cntrIR_n = 1'b0; repeat (HOLD) wait_sample();
            cntrIR_n = 1'b1; repeat (HOLD) wait_sample();
        end
        check("sat_line_cnt", line_cnt, 15);
        cntrIR_n = 1'b0;
        repeat (HOLD - 1) wait_sample();
        wait_pre_sample();
        clr_cnt = 1'b1;
        wait_sample();
        clr_cnt = 1'b0;
        check("clr_with_rise_cnt", line_cnt, 1);
        check("clr_with_rise_pulse", cntr_rise, 1);
        cntrIR_n = 1'b1;
        repeat (HOLD) wait_sample();

`ifdef IR_GLITCH_FILT_EN
        lftIR_n = 1'b0; repeat (2) wait_sample();
        lftIR_n = 1'b1; wait_sample();
        check("filt_short_pulse_lft", lftIR, 0);
        lftIR_n = 1'b0; repeat (2) wait_sample();
        check("filt_two_low_lft", lftIR, 0);
        wait_sample();
        check("filt_three_low_lft", lftIR, 1);
        lftIR_n = 1'b1; repeat (HOLD) wait_sample();
`endif

        // en drop clears levels, holds line_cnt.
        lftIR_n = 1'b0; rghtIR_n = 1'b0;
        repeat (HOLD) wait_sample();
        check("pre_drop_lft", lftIR, 1);
        en = 1'b0;
        step(1);
        check("drop_lft_cleared", lftIR, 0);
        check("drop_rght_cleared", rghtIR, 0);
        check("drop_line_cnt_held", line_cnt, 1);
        lftIR_n = 1'b1; rghtIR_n = 1'b1;
        step(4);
        // en raised after edge 0, dropped after edge 5 (mid-SETTLE)
        en = 1'b1;
        step(5);
        check("midsettle_IR_en_on", IR_en, 1);
        en = 1'b0;
        step(1);
        check("midsettle_IR_en_off", IR_en, 0);
        step(3 * SETTLE);
        check("midsettle_line_cnt", line_cnt, 1);
        en = 1'b1;
        wait_sample();

        // Reach line_cnt=5 then reset mid-OFF.
        step(2); clr_cnt = 1'b1; step(1); clr_cnt = 1'b0;
        wait_sample();
        for (int i = 0; i < 5; i++) begin
            cntrIR_n = 1'b0; repeat (HOLD) wait_sample();
            cntrIR_n = 1'b1; repeat (HOLD) wait_sample();
        end
        lftIR_n = 1'b0;
        repeat (HOLD) wait_sample();
        check("pre_reset_line_cnt", line_cnt, 5);
        check("pre_reset_lft", lftIR, 1);
        step(20);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_IR_en", IR_en, 0);
        check("async_rst_lftIR", lftIR, 0);
        check("async_rst_cntrIR", cntrIR, 0);
        check("async_rst_rghtIR", rghtIR, 0);
        check("async_rst_smpl_vld", smpl_vld, 0);
        check("async_rst_cntr_rise", cntr_rise, 0);
        check("async_rst_line_cnt", line_cnt, 0);
        lftIR_n = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_IR_en", IR_en, 1);
        wait_sample();

        // Randomized scans.
        for (int it = 0; it < 40; it++) begin
            {lftIR_n, cntrIR_n, rghtIR_n} = 3'($urandom);
            case ($urandom % 8)
                0: begin
                    wait_pre_sample();
                    clr_cnt = 1'b1;
                    wait_sample();
                    clr_cnt = 1'b0;
                end
                1: begin
                    step($urandom_range(2, 40));
                    clr_cnt = 1'b1;
                    step(1);
                    clr_cnt = 1'b0;
                    wait_sample();
                end
                2: begin
                    step($urandom_range(1, 60));
                    en = 1'b0;
                    step($urandom_range(1, 5));
                    {lftIR_n, cntrIR_n, rghtIR_n} = 3'($urandom);
                    en = 1'b1;
                    wait_sample();
                end
                default: wait_sample();
            endcase
        end

        en = 1'b0;
        step(5);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/ir_scan_ctrl.md
# ir_scan_ctrl

Sequencer for the Knight's IR guardrail and center-line sensors. It duty-cycles the IR emitter enable, waits a fixed settle time, then samples the three raw active-low IR inputs. It filters the samples and presents qualified sensor levels, a center-line crossing pulse and a saturating crossing count to the tour/navigation logic. It sits between the physical `IR_en`/`lftIR_n`/`cntrIR_n`/`rghtIR_n` pins and the command/PID logic.

## Interface
Parameters:
- `PERIOD`, 2048: scan period in clk cycles. Must satisfy PERIOD > SETTLE+1.
- `SETTLE`, 256: cycles `IR_en` is high before the sample. Must be ≥3 to cover the 2-flop synchronizer.
- `FILT_N`, 3: number of consecutive equal samples needed to accept a new level. Used only with the filter macro.

Ports:
- `clk`  in  1  50MHz system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  scanning enabled (robot moving)
- `clr_cnt`  in  1  synchronous clear of `line_cnt`
- `lftIR_n`, `cntrIR_n`, `rghtIR_n`  in  1 each  raw asynchronous active-low sensor inputs
- `IR_en`  out  1  IR emitter enable
- `lftIR`, `cntrIR`, `rghtIR`  out  1 each  qualified active-high sensor levels
- `smpl_vld`  out  1  one-cycle pulse when outputs are updated
- `cntr_rise`  out  1  one-cycle pulse marking an accepted 0→1 on `cntrIR`
- `line_cnt`  out  4  center-line crossings, saturates at 15

## Operation
- Each raw input passes through a 2-flop synchronizer and is inverted to active-high.
- FSM states:
  - IDLE → SETTLE when `en`=1.
  - SETTLE: `IR_en`=1, counter runs 0..SETTLE-1, then → SAMPLE.
  - SAMPLE: `IR_en`=1 for one cycle, synced values captured, then → OFF.
  - OFF: `IR_en`=0 for PERIOD-SETTLE-1 cycles, then → SETTLE.
- `en`=0 in any state → IDLE on the next edge:
  - `IR_en` drops.
  - A pending sample is discarded (no `smpl_vld`).
  - `lftIR`/`cntrIR`/`rghtIR` clear to 0.
  - `line_cnt` is held.
- Each captured sample passes through the filter (see Configuration), then updates the outputs.
- `cntr_rise` is asserted when the accepted `cntrIR` goes 0→1.
- `line_cnt`:
  - Increments on `cntr_rise` and saturates at 4'hF.
  - `clr_cnt` clears it to 0.
  - `clr_cnt` together with `cntr_rise` → 1.
- Period/settle counter width is $clog2(PERIOD). The counter never wraps past its terminal value; it reloads to 0 on each state change.

## Timing
- Reset values: state IDLE; `IR_en`, `lftIR`, `cntrIR`, `rghtIR`, `smpl_vld`, `cntr_rise` all 0; `line_cnt` 0; filter histories 0.
- `en` rises at edge k → `IR_en`=1 from edge k+1.
- The SAMPLE cycle is edge k+1+SETTLE. Outputs, `smpl_vld` and `cntr_rise` update at edge k+2+SETTLE.
- `IR_en` high for exactly SETTLE+1 cycles per scan; scan-to-scan spacing is exactly PERIOD cycles.
- Input-to-output latency: 2 sync cycles plus wait-to-sample plus 1 register cycle.
- `smpl_vld` pulses once per PERIOD while `en`=1. `cntr_rise` is only ever high together with `smpl_vld`.
- Reset asserted mid-scan returns everything to reset values immediately. `en` is still high when reset releases → scanning restarts as from IDLE.

## Configuration
- `IR_GLITCH_FILT_EN` defined:
  - Per-channel filter; a new level is accepted only after FILT_N consecutive identical samples.
  - Otherwise the previous accepted level is held and `smpl_vld` still pulses.
  - Histories clear when `en` drops.
- Undefined: each sample is accepted directly; FILT_N is ignored.

## Structure
- `ir_pkg`: state enum typedef (IDLE, SETTLE, SAMPLE, OFF) and default PERIOD/SETTLE/FILT_N constants.
- Sub-module `ir_glitch_filt`: one channel's synchronizer plus optional filter, instantiated three times. The FSM, counter and line counter stay in the top level.

## Test plan
Sim overrides: PERIOD=64, SETTLE=8.
- Reset, then `en`=1 at edge 0 → `IR_en` high edges 1–9 and low edges 10–64; `smpl_vld` pulses at edge 10 and again at edge 74.
- `cntrIR_n` held 0 for one scan then 1 (filter off) → `cntrIR`=1 and `cntr_rise` pulse at first `smpl_vld`; `line_cnt`=1; `cntrIR`=0 at the next.
- 17 center-line crossings → `line_cnt`=15 (saturated). `clr_cnt` together with an 18th rise → `line_cnt`=1.
- `en` dropped at edge 5 (mid-SETTLE) → `IR_en`=0 at edge 6; no `smpl_vld`; outputs 0; `line_cnt` unchanged.
- `IR_GLITCH_FILT_EN`, FILT_N=3: `lftIR_n` low for 2 scans then high → `lftIR` stays 0. Low for 3 scans → `lftIR`=1 at the third `smpl_vld`.
- `rst_n` pulsed mid-OFF with `line_cnt`=5 → all outputs 0 and `line_cnt`=0 immediately; with `en`=1, `IR_en` rises 1 cycle after release.
